// File: rtl/prediction_stat_tracker_if.sv
// Bundles the arbiter-side prediction push, resolve/flush control and the
// per-predictor confidence outputs of prediction_stat_tracker.
interface prediction_stat_tracker_if #(
  parameter int STAT_COUNTER_WIDTH = 5
);
  logic                          pred_valid;
  logic                          SP_prediction_result;
  logic                          LHP_prediction_result;
  logic                          GHP_prediction_result;
  logic                          pred_ready;
  logic                          resolve_valid;
  logic                          resolve_taken;
  logic                          flush;
  logic                          resolve_orphan;
  logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count;
  logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count;
  logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count;
  logic [3:0]                    SP_trend_decode;
  logic [3:0]                    LHP_trend_decode;
  logic [3:0]                    GHP_trend_decode;

  modport master (
    output pred_valid, SP_prediction_result, LHP_prediction_result,
           GHP_prediction_result, resolve_valid, resolve_taken, flush,
    input  pred_ready, resolve_orphan, SP_stat_count, LHP_stat_count,
           GHP_stat_count, SP_trend_decode, LHP_trend_decode, GHP_trend_decode
  );

  modport slave (
    input  pred_valid, SP_prediction_result, LHP_prediction_result,
           GHP_prediction_result, resolve_valid, resolve_taken, flush,
    output pred_ready, resolve_orphan, SP_stat_count, LHP_stat_count,
           GHP_stat_count, SP_trend_decode, LHP_trend_decode, GHP_trend_decode
  );
endinterface

// File: rtl/prediction_stat_tracker.sv
// Buffers SP/LHP/GHP predictions per in-flight branch and, on resolve, scores
// each predictor into a saturating confidence counter and a one-hot trend.
module prediction_stat_tracker #(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  prediction_stat_tracker_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  localparam logic [STAT_COUNTER_WIDTH-1:0] CNT_INIT =
    {1'b1, {(STAT_COUNTER_WIDTH-1){1'b0}}};
  localparam logic [STAT_COUNTER_WIDTH-1:0] CNT_ONE  = STAT_COUNTER_WIDTH'(1);
  localparam logic [STAT_COUNTER_WIDTH-1:0] CNT_MAX  = {STAT_COUNTER_WIDTH{1'b1}};

  localparam logic [3:0] TR_SC = 4'b1000;
  localparam logic [3:0] TR_WC = 4'b0100;
  localparam logic [3:0] TR_WW = 4'b0010;
  localparam logic [3:0] TR_SW = 4'b0001;

  logic [2:0]                    fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_r;
  logic [PTR_W-1:0]              rd_ptr_r;
  logic [OCC_W-1:0]              occ_r;
  logic                          orphan_r;
  logic [STAT_COUNTER_WIDTH-1:0] sp_cnt_r, lhp_cnt_r, ghp_cnt_r;
  logic [3:0]                    sp_tr_r, lhp_tr_r, ghp_tr_r;

  logic                          full_s;
  logic                          empty_s;
  logic                          push_s;
  logic                          pop_s;
  logic [2:0]                    head_s;
  logic [2:0]                    hit_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? PTR_ZERO : ptr + PTR_ONE;
  endfunction

  function automatic logic [STAT_COUNTER_WIDTH-1:0] stat_next(
    input logic [STAT_COUNTER_WIDTH-1:0] cnt,
    input logic                          hit
  );
    if (hit) begin
      return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end else begin
      return cnt >> 1;
    end
  endfunction

  // An illegal (non one-hot) trend recovers to weakly correct.
  function automatic logic [3:0] trend_next(input logic [3:0] tr, input logic hit);
    case (tr)
      TR_SC:   return hit ? TR_SC : TR_WC;
      TR_WC:   return hit ? TR_SC : TR_WW;
      TR_WW:   return hit ? TR_WC : TR_SW;
      TR_SW:   return hit ? TR_WW : TR_SW;
      default: return TR_WC;
    endcase
  endfunction

  // FIFO status, accepted push/pop and per-predictor correctness of the head entry.
  always_comb begin
    full_s  = (occ_r == OCC_FULL);
    empty_s = (occ_r == OCC_ZERO);
    pop_s   = bus.resolve_valid && !empty_s;
    push_s  = bus.pred_valid && !full_s && !bus.flush;
    head_s  = fifo_mem_r[rd_ptr_r];
    hit_s   = ~(head_s ^ {3{bus.resolve_taken}});
  end

  // Pointer and occupancy tracking; flush empties the queue after the pop is scored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else if (bus.flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Entry storage, packed as {SP, LHP, GHP}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 3'b000;
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {bus.SP_prediction_result,
                               bus.LHP_prediction_result,
                               bus.GHP_prediction_result};
    end
  end

  // Orphan pulse: a resolve that found no in-flight branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_r <= 1'b0;
    end else begin
      orphan_r <= bus.resolve_valid && empty_s;
    end
  end

  // Confidence counters and trends, all three scored together on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_cnt_r  <= CNT_INIT;
      lhp_cnt_r <= CNT_INIT;
      ghp_cnt_r <= CNT_INIT;
      sp_tr_r   <= TR_WC;
      lhp_tr_r  <= TR_WC;
      ghp_tr_r  <= TR_WC;
    end else if (pop_s) begin
      sp_cnt_r  <= stat_next(sp_cnt_r,  hit_s[2]);
      lhp_cnt_r <= stat_next(lhp_cnt_r, hit_s[1]);
      ghp_cnt_r <= stat_next(ghp_cnt_r, hit_s[0]);
      sp_tr_r   <= trend_next(sp_tr_r,  hit_s[2]);
      lhp_tr_r  <= trend_next(lhp_tr_r, hit_s[1]);
      ghp_tr_r  <= trend_next(ghp_tr_r, hit_s[0]);
    end
  end

  assign bus.pred_ready       = !full_s;
  assign bus.resolve_orphan   = orphan_r;
  assign bus.SP_stat_count    = sp_cnt_r;
  assign bus.LHP_stat_count   = lhp_cnt_r;
  assign bus.GHP_stat_count   = ghp_cnt_r;
  assign bus.SP_trend_decode  = sp_tr_r;
  assign bus.LHP_trend_decode = lhp_tr_r;
  assign bus.GHP_trend_decode = ghp_tr_r;

endmodule

// File: tb/tb_prediction_stat_tracker.sv
// Directed self-checking bench for prediction_stat_tracker.
module tb_prediction_stat_tracker;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  prediction_stat_tracker_if #(.STAT_COUNTER_WIDTH(5)) bus ();

  prediction_stat_tracker #(
    .STAT_COUNTER_WIDTH(5),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {SP cnt, LHP cnt, GHP cnt, SP trend, LHP trend, GHP trend}
  function automatic logic [26:0] obs();
    return {bus.SP_stat_count, bus.LHP_stat_count, bus.GHP_stat_count,
            bus.SP_trend_decode, bus.LHP_trend_decode, bus.GHP_trend_decode};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pred_valid            = 1'b0;
    bus.SP_prediction_result  = 1'b0;
    bus.LHP_prediction_result = 1'b0;
    bus.GHP_prediction_result = 1'b0;
    bus.resolve_valid         = 1'b0;
    bus.resolve_taken         = 1'b0;
    bus.flush                 = 1'b0;
  endtask

  // One cycle of stimulus, then back to idle.
  task automatic drive(input logic pv, input logic [2:0] bits,
                       input logic rv, input logic rt, input logic fl);
    bus.pred_valid = pv;
    {bus.SP_prediction_result, bus.LHP_prediction_result,
     bus.GHP_prediction_result} = bits;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.flush         = fl;
    step();
    idle();
  endtask

  task automatic push(input logic [2:0] bits);
    drive(1'b1, bits, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    drive(1'b0, 3'b000, 1'b1, rt, 1'b0);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [26:0] exp_v;
    apply_reset();
    exp_v = {5'd16, 5'd16, 5'd16, 4'b0100, 4'b0100, 4'b0100};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_fail++; $display("FAIL reset_state got %h expected %h", obs(), exp_v);
    end
    n_cmp++;
    if ({bus.pred_ready, bus.resolve_orphan} !== 2'b10) begin
      n_fail++; $display("FAIL reset_flags got %b expected 10",
                         {bus.pred_ready, bus.resolve_orphan});
    end
  endtask

  task automatic test_saturation();
    logic [26:0] exp_v;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      push(3'b110);
      resolve(1'b1);
      case (k)
        1:  exp_v = {5'd17, 5'd17, 5'd8, 4'b1000, 4'b1000, 4'b0010};
        2:  exp_v = {5'd18, 5'd18, 5'd4, 4'b1000, 4'b1000, 4'b0001};
        5:  exp_v = {5'd21, 5'd21, 5'd0, 4'b1000, 4'b1000, 4'b0001};
        20: exp_v = {5'd31, 5'd31, 5'd0, 4'b1000, 4'b1000, 4'b0001};
        default: exp_v = 27'd0;
      endcase
      if (k == 1 || k == 2 || k == 5 || k == 20) begin
        n_cmp++;
        if (obs() !== exp_v) begin
          n_fail++; $display("FAIL saturation_k%0d got %h expected %h", k, obs(), exp_v);
        end
      end
    end
  endtask

  task automatic test_order_wrap();
    logic [2:0]  ent [4];
    logic [26:0] exp_t [12];
    ent[0] = 3'b100; ent[1] = 3'b010; ent[2] = 3'b001; ent[3] = 3'b111;
    exp_t[0]  = {5'd8,  5'd17, 5'd17, 4'b0010, 4'b1000, 4'b1000};
    exp_t[1]  = {5'd9,  5'd8,  5'd18, 4'b0100, 4'b0100, 4'b1000};
    exp_t[2]  = {5'd10, 5'd9,  5'd9,  4'b1000, 4'b1000, 4'b0100};
    exp_t[3]  = {5'd5,  5'd4,  5'd4,  4'b0100, 4'b0100, 4'b0010};
    exp_t[4]  = {5'd2,  5'd5,  5'd5,  4'b0010, 4'b1000, 4'b0100};
    exp_t[5]  = {5'd3,  5'd2,  5'd6,  4'b0100, 4'b0100, 4'b1000};
    exp_t[6]  = {5'd4,  5'd3,  5'd3,  4'b1000, 4'b1000, 4'b0100};
    exp_t[7]  = {5'd2,  5'd1,  5'd1,  4'b0100, 4'b0100, 4'b0010};
    exp_t[8]  = {5'd1,  5'd2,  5'd2,  4'b0010, 4'b1000, 4'b0100};
    exp_t[9]  = {5'd2,  5'd1,  5'd3,  4'b0100, 4'b0100, 4'b1000};
    exp_t[10] = {5'd3,  5'd2,  5'd1,  4'b1000, 4'b1000, 4'b0100};
    exp_t[11] = {5'd1,  5'd1,  5'd0,  4'b0100, 4'b0100, 4'b0010};
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) push(ent[i]);
      for (int i = 0; i < 4; i++) begin
        resolve(1'b0);
        n_cmp++;
        if (obs() !== exp_t[r*4+i]) begin
          n_fail++; $display("FAIL order_r%0d_e%0d got %h expected %h",
                             r, i, obs(), exp_t[r*4+i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [26:0] exp_v;
    apply_reset();
    for (int i = 0; i < 4; i++) push(3'b111);
    n_cmp++;
    if (bus.pred_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready got %b expected 0", bus.pred_ready);
    end
    push(3'b000);
    for (int i = 0; i < 4; i++) resolve(1'b1);
    exp_v = {5'd20, 5'd20, 5'd20, 4'b1000, 4'b1000, 4'b1000};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_fail++; $display("FAIL full_drain got %h expected %h", obs(), exp_v);
    end
    resolve(1'b1);
    n_cmp++;
    if ({bus.resolve_orphan, obs()} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL fifth_push_dropped got %b/%h expected 1/%h",
                         bus.resolve_orphan, obs(), exp_v);
    end
    // Push+pop at three entries keeps occupancy at three.
    apply_reset();
    for (int i = 0; i < 3; i++) push(3'b111);
    drive(1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    exp_v = {5'd17, 5'd17, 5'd17, 4'b1000, 4'b1000, 4'b1000};
    n_cmp++;
    if ({bus.pred_ready, obs()} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL push_pop_same got %b/%h expected 1/%h",
                         bus.pred_ready, obs(), exp_v);
    end
    push(3'b111);
    n_cmp++;
    if (bus.pred_ready !== 1'b0) begin
      n_fail++; $display("FAIL occ_three_then_full got %b expected 0", bus.pred_ready);
    end
  endtask

  task automatic test_flush();
    logic [26:0] exp_v;
    apply_reset();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    exp_v = {5'd16, 5'd16, 5'd16, 4'b0100, 4'b0100, 4'b0100};
    n_cmp++;
    if ({bus.pred_ready, bus.resolve_orphan, obs()} !== {2'b10, exp_v}) begin
      n_fail++; $display("FAIL flush_empty got %h expected %h",
                         {bus.pred_ready, bus.resolve_orphan, obs()}, {2'b10, exp_v});
    end
    push(3'b100); push(3'b000); push(3'b000);
    drive(1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
    exp_v = {5'd17, 5'd8, 5'd8, 4'b1000, 4'b0010, 4'b0010};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_fail++; $display("FAIL flush_score_oldest got %h expected %h", obs(), exp_v);
    end
    // Orphan resolve with a simultaneous push that must be accepted.
    drive(1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.resolve_orphan, obs()} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL flush_orphan got %b/%h expected 1/%h",
                         bus.resolve_orphan, obs(), exp_v);
    end
    resolve(1'b1);
    exp_v = {5'd18, 5'd9, 5'd9, 4'b1000, 4'b0100, 4'b0100};
    n_cmp++;
    if ({bus.resolve_orphan, obs()} !== {1'b0, exp_v}) begin
      n_fail++; $display("FAIL orphan_push_kept got %b/%h expected 0/%h",
                         bus.resolve_orphan, obs(), exp_v);
    end
  endtask

  task automatic test_async_reset();
    logic [26:0] exp_v;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      push(3'b100);
      resolve(1'b1);
    end
    push(3'b111); push(3'b111);
    n_cmp++;
    if (bus.SP_stat_count !== 5'd31) begin
      n_fail++; $display("FAIL pre_reset_sp got %0d expected 31", bus.SP_stat_count);
    end
    #3 rst = 1'b1;
    #1;
    exp_v = {5'd16, 5'd16, 5'd16, 4'b0100, 4'b0100, 4'b0100};
    n_cmp++;
    if ({bus.pred_ready, bus.resolve_orphan, obs()} !== {2'b10, exp_v}) begin
      n_fail++; $display("FAIL async_reset got %h expected %h",
                         {bus.pred_ready, bus.resolve_orphan, obs()}, {2'b10, exp_v});
    end
    step();
    rst = 1'b0;
    resolve(1'b1);
    n_cmp++;
    if ({bus.resolve_orphan, obs()} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL post_reset_orphan got %b/%h expected 1/%h",
                         bus.resolve_orphan, obs(), exp_v);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_saturation();
    test_order_wrap();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
